// File: rtl/mips_cpu_regfile_wr_arbiter_if.sv
// Writeback, scoreboard and hazard bundle for the regfile write arbiter.
// master = surrounding pipeline, slave = arbiter.
interface mips_cpu_regfile_wr_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              rf_write;
    logic [ADDR_W-1:0] rf_wrAddr;
    logic [DATA_W-1:0] rf_wrData;

    logic              reserve_valid;
    logic [ADDR_W-1:0] reserve_addr;

    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic              hazard_a;
    logic              hazard_b;
    logic [ADDR_W:0]   pending_cnt;

    modport master (
        output alu_valid, alu_addr, alu_data,
        input  alu_ready,
        output mem_valid, mem_addr, mem_data,
        input  mem_ready,
        input  rf_write, rf_wrAddr, rf_wrData,
        output reserve_valid, reserve_addr,
        output rd_addr_a, rd_addr_b,
        input  hazard_a, hazard_b, pending_cnt
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        output alu_ready,
        input  mem_valid, mem_addr, mem_data,
        output mem_ready,
        output rf_write, rf_wrAddr, rf_wrData,
        input  reserve_valid, reserve_addr,
        input  rd_addr_a, rd_addr_b,
        output hazard_a, hazard_b, pending_cnt
    );
endinterface

// File: rtl/mips_cpu_regfile_wr_arbiter.sv
// Round-robin arbiter for the single regfile write port (ALU vs load),
// with a pending-write scoreboard and read-hazard flags.
// Ports: clk, reset (sync, active-high), bus (slave side of the bundle):
//   alu_*/mem_* valid/ready requesters, rf_* registered write port,
//   reserve_* scoreboard set, rd_addr_*/hazard_* checks, pending_cnt.
module mips_cpu_regfile_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int INIT_PRI_MEM = 1
) (
    input  logic clk,
    input  logic reset,
    mips_cpu_regfile_wr_arbiter_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;

    // pri_q = 1: load requester wins the next contention
    logic              pri_q, pri_d;
    logic              rf_write_q, rf_write_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic [NREG-1:0]   pend_q, pend_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    logic              alu_gnt, mem_gnt, any_gnt, contended;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    always_comb begin
        contended = bus.alu_valid && bus.mem_valid && !reset;
        alu_gnt   = !reset && bus.alu_valid
                  && (!bus.mem_valid || !pri_q);
        mem_gnt   = !reset && bus.mem_valid
                  && (!bus.alu_valid || pri_q);
        any_gnt   = alu_gnt || mem_gnt;
        gnt_addr  = mem_gnt ? bus.mem_addr : bus.alu_addr;
        gnt_data  = mem_gnt ? bus.mem_data : bus.alu_data;
    end

    always_comb begin
        pri_d      = pri_q;
        rf_write_d = 1'b0;
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        pend_d     = pend_q;
        cnt_d      = '0;

        if (contended) pri_d = !pri_q;

        // A grant to r0 is consumed but never reaches the regfile
        if (any_gnt) begin
            rf_write_d = (gnt_addr != '0);
            rf_addr_d  = gnt_addr;
            rf_data_d  = gnt_data;
        end

        // Clear before set: a new producer reserving the same
        // register on the retiring edge keeps the bit set
        if (any_gnt && gnt_addr != '0)
            pend_d[gnt_addr] = 1'b0;
        if (bus.reserve_valid && bus.reserve_addr != '0)
            pend_d[bus.reserve_addr] = 1'b1;

        for (int i = 0; i < NREG; i++)
            cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pri_q      <= (INIT_PRI_MEM != 0);
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            pend_q     <= '0;
            cnt_q      <= '0;
        end else begin
            pri_q      <= pri_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.alu_ready   = alu_gnt;
    assign bus.mem_ready   = mem_gnt;
    assign bus.rf_write    = rf_write_q;
    assign bus.rf_wrAddr   = rf_addr_q;
    assign bus.rf_wrData   = rf_data_q;
    assign bus.pending_cnt = cnt_q;

    // The regfile read is registered, so a register being written
    // this cycle still reads stale data.
    assign bus.hazard_a = (bus.rd_addr_a != '0)
        && (pend_q[bus.rd_addr_a]
            || (rf_write_q && rf_addr_q == bus.rd_addr_a));
    assign bus.hazard_b = (bus.rd_addr_b != '0)
        && (pend_q[bus.rd_addr_b]
            || (rf_write_q && rf_addr_q == bus.rd_addr_b));
endmodule

// File: tb/tb_mips_cpu_regfile_wr_arbiter.sv
// Self-checking bench for mips_cpu_regfile_wr_arbiter:
// directed scenarios plus a randomized run against a reference model.
module tb_mips_cpu_regfile_wr_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;

    mips_cpu_regfile_wr_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    mips_cpu_regfile_wr_arbiter #(
        .DATA_W(32), .ADDR_W(5), .INIT_PRI_MEM(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle;
        bus.alu_valid = 0; bus.alu_addr = 0; bus.alu_data = 0;
        bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_data = 0;
        bus.reserve_valid = 0; bus.reserve_addr = 0;
        bus.rd_addr_a = 0; bus.rd_addr_b = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        idle();
        @(negedge clk);
        bus.alu_valid = 1; bus.mem_valid = 1;
        bus.alu_addr = 5; bus.mem_addr = 6;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got alu=%b mem=%b want 0 0",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b0 || bus.rf_wrAddr !== 5'd0
            || bus.rf_wrData !== 32'd0 || bus.pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_state: got w=%b a=%0d d=%h c=%0d want 0 0 0 0",
                     bus.rf_write, bus.rf_wrAddr, bus.rf_wrData, bus.pending_cnt);
        end
        @(negedge clk);
        reset = 0;
        idle();
    endtask

    task automatic test_single_write;
        @(negedge clk);
        bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ready: got alu=%b mem=%b want 1 0",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd5
            || bus.rf_wrData !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL single_write: got w=%b a=%0d d=%h want 1 5 deadbeef",
                     bus.rf_write, bus.rf_wrAddr, bus.rf_wrData);
        end
        @(negedge clk);
        idle();
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL single_after: got w=%b want 0", bus.rf_write);
        end
    endtask

    task automatic test_contention;
        @(negedge clk);
        bus.mem_valid = 1; bus.mem_addr = 3; bus.mem_data = 32'h3333;
        bus.alu_valid = 1; bus.alu_addr = 4; bus.alu_data = 32'h4444;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b1 || bus.alu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cont1_ready: got mem=%b alu=%b want 1 0",
                     bus.mem_ready, bus.alu_ready);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd3
            || bus.rf_wrData !== 32'h3333) begin
            n_fail++;
            $display("FAIL cont1_write: got w=%b a=%0d d=%h want 1 3 3333",
                     bus.rf_write, bus.rf_wrAddr, bus.rf_wrData);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b0 || bus.alu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cont2_ready: got mem=%b alu=%b want 0 1",
                     bus.mem_ready, bus.alu_ready);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b1 || bus.rf_wrAddr !== 5'd4
            || bus.rf_wrData !== 32'h4444) begin
            n_fail++;
            $display("FAIL cont2_write: got w=%b a=%0d d=%h want 1 4 4444",
                     bus.rf_write, bus.rf_wrAddr, bus.rf_wrData);
        end
        @(negedge clk);
        idle();
        tick();
    endtask

    task automatic test_scoreboard;
        @(negedge clk);
        bus.reserve_valid = 1; bus.reserve_addr = 7; bus.rd_addr_a = 7;
        tick();
        n_checks++;
        if (bus.hazard_a !== 1'b1 || bus.pending_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL sb_reserve: got haz=%b cnt=%0d want 1 1",
                     bus.hazard_a, bus.pending_cnt);
        end
        @(negedge clk);
        bus.reserve_valid = 0;
        bus.mem_valid = 1; bus.mem_addr = 7; bus.mem_data = 32'h77;
        #1;
        n_checks++;
        if (bus.mem_ready !== 1'b1 || bus.hazard_a !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_grant: got rdy=%b haz=%b want 1 1",
                     bus.mem_ready, bus.hazard_a);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b1 || bus.hazard_a !== 1'b1
            || bus.pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL sb_wrcycle: got w=%b haz=%b cnt=%0d want 1 1 0",
                     bus.rf_write, bus.hazard_a, bus.pending_cnt);
        end
        @(negedge clk);
        bus.mem_valid = 0;
        tick();
        n_checks++;
        if (bus.hazard_a !== 1'b0 || bus.rf_write !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_done: got haz=%b w=%b want 0 0",
                     bus.hazard_a, bus.rf_write);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_same_cycle;
        @(negedge clk);
        bus.reserve_valid = 1; bus.reserve_addr = 9; bus.rd_addr_b = 9;
        tick();
        @(negedge clk);
        bus.alu_valid = 1; bus.alu_addr = 9; bus.alu_data = 32'h99;
        tick();
        n_checks++;
        if (bus.pending_cnt !== 6'd1 || bus.hazard_b !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle: got cnt=%0d haz=%b want 1 1",
                     bus.pending_cnt, bus.hazard_b);
        end
        @(negedge clk);
        bus.alu_valid = 0; bus.reserve_valid = 0;
        tick();
        n_checks++;
        if (bus.hazard_b !== 1'b1 || bus.pending_cnt !== 6'd1) begin
            n_fail++;
            $display("FAIL same_hold: got haz=%b cnt=%0d want 1 1",
                     bus.hazard_b, bus.pending_cnt);
        end
        @(negedge clk);
        bus.alu_valid = 1;
        tick();
        @(negedge clk);
        bus.alu_valid = 0;
        tick();
        n_checks++;
        if (bus.hazard_b !== 1'b0 || bus.pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL same_clear: got haz=%b cnt=%0d want 0 0",
                     bus.hazard_b, bus.pending_cnt);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_addr0;
        @(negedge clk);
        bus.alu_valid = 1; bus.alu_addr = 0; bus.alu_data = 32'h1234;
        bus.reserve_valid = 1; bus.reserve_addr = 0; bus.rd_addr_a = 0;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b1 || bus.hazard_a !== 1'b0) begin
            n_fail++;
            $display("FAIL addr0_ready: got rdy=%b haz=%b want 1 0",
                     bus.alu_ready, bus.hazard_a);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b0 || bus.pending_cnt !== 6'd0
            || bus.hazard_a !== 1'b0) begin
            n_fail++;
            $display("FAIL addr0_write: got w=%b cnt=%0d haz=%b want 0 0 0",
                     bus.rf_write, bus.pending_cnt, bus.hazard_a);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_midop;
        for (int r = 1; r <= 3; r++) begin
            @(negedge clk);
            bus.reserve_valid = 1; bus.reserve_addr = 5'(r);
            tick();
        end
        n_checks++;
        if (bus.pending_cnt !== 6'd3) begin
            n_fail++;
            $display("FAIL midop_cnt: got %0d want 3", bus.pending_cnt);
        end
        @(negedge clk);
        bus.reserve_valid = 0;
        bus.alu_valid = 1; bus.alu_addr = 11; bus.alu_data = 32'hB;
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_inflight: got w=%b want 1", bus.rf_write);
        end
        @(negedge clk);
        reset = 1;
        bus.mem_valid = 1; bus.mem_addr = 12;
        #1;
        n_checks++;
        if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midop_ready: got alu=%b mem=%b want 0 0",
                     bus.alu_ready, bus.mem_ready);
        end
        tick();
        n_checks++;
        if (bus.rf_write !== 1'b0 || bus.pending_cnt !== 6'd0) begin
            n_fail++;
            $display("FAIL midop_reset: got w=%b cnt=%0d want 0 0",
                     bus.rf_write, bus.pending_cnt);
        end
        @(negedge clk);
        reset = 0;
        idle();
    endtask

    // Reference model: set of pending registers, the requester that
    // wins the next contention, and the write seen on the port.
    task automatic test_random;
        bit pend[32];
        bit mem_next = 1;
        bit m_wr = 0;
        int m_waddr = 0;
        logic [31:0] m_wdata = 0;
        bit av = 0, mv = 0;
        logic [4:0] aa = 0, ma = 0;
        logic [31:0] ad = 0, md = 0;
        foreach (pend[i]) pend[i] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bit ga, gm, ha, hb, rv;
            int ra, rb, rsv, g_addr, cnt;
            logic [31:0] g_data;
            @(negedge clk);
            if (!av && $urandom_range(0, 2) != 0) begin
                av = 1; aa = 5'($urandom_range(0, 7)); ad = $urandom;
            end
            if (!mv && $urandom_range(0, 2) != 0) begin
                mv = 1; ma = 5'($urandom_range(0, 7)); md = $urandom;
            end
            rv = ($urandom_range(0, 2) == 0);
            rsv = $urandom_range(0, 7);
            ra = $urandom_range(0, 7);
            rb = $urandom_range(0, 7);
            bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
            bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
            bus.reserve_valid = rv; bus.reserve_addr = 5'(rsv);
            bus.rd_addr_a = 5'(ra); bus.rd_addr_b = 5'(rb);
            #1;
            if (av && mv) begin
                gm = mem_next; ga = !mem_next;
            end else begin
                gm = mv; ga = av;
            end
            ha = ra != 0 && (pend[ra] || (m_wr && m_waddr == ra));
            hb = rb != 0 && (pend[rb] || (m_wr && m_waddr == rb));
            n_checks++;
            if (bus.alu_ready !== ga || bus.mem_ready !== gm
                || bus.hazard_a !== ha || bus.hazard_b !== hb) begin
                n_fail++;
                $display("FAIL rand_comb cyc%0d: got rdy=%b%b haz=%b%b want %b%b %b%b",
                         cyc, bus.alu_ready, bus.mem_ready,
                         bus.hazard_a, bus.hazard_b, ga, gm, ha, hb);
            end
            tick();
            if (av && mv) mem_next = !mem_next;
            g_addr = gm ? int'(ma) : int'(aa);
            g_data = gm ? md : ad;
            m_wr = (ga || gm) && g_addr != 0;
            if (m_wr) begin
                m_waddr = g_addr; m_wdata = g_data;
                pend[g_addr] = 0;
            end
            if (rv && rsv != 0) pend[rsv] = 1;
            cnt = 0;
            foreach (pend[i]) cnt += int'(pend[i]);
            if (ga) av = 0;
            if (gm) mv = 0;
            n_checks++;
            if (bus.rf_write !== m_wr || bus.pending_cnt !== 6'(cnt)
                || (m_wr && (bus.rf_wrAddr !== 5'(m_waddr)
                             || bus.rf_wrData !== m_wdata))) begin
                n_fail++;
                $display("FAIL rand_seq cyc%0d: got w=%b a=%0d d=%h c=%0d want %b %0d %h %0d",
                         cyc, bus.rf_write, bus.rf_wrAddr, bus.rf_wrData,
                         bus.pending_cnt, m_wr, m_waddr, m_wdata, cnt);
            end
        end
        @(negedge clk);
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard();
        test_same_cycle();
        test_addr0();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_cpu_regfile_wr_arbiter.md
Name: mips_cpu_regfile_wr_arbiter

Overview:
Arbitrates the single register-file write port between two writeback requesters: the ALU result path and the load-data path. Each requester uses a valid/ready handshake. The block keeps a pending-write scoreboard that decode sets for each destination register, and it raises read-hazard flags for both read ports. It sits between the writeback sources and the register file, and drives the register file's write, wrAddr and wrData inputs from registered outputs.

Parameters:
DATA_W, 32, width of write data.
ADDR_W, 5, register address width; 2**ADDR_W registers.
INIT_PRI_MEM, 1, 1 = load requester wins the first contention after reset; 0 = ALU requester wins.

Ports:
clk  input  1  clock.
reset  input  1  reset, synchronous, active-high.
alu_valid  input  1  ALU writeback request.
alu_addr  input  ADDR_W  ALU destination register.
alu_data  input  DATA_W  ALU result.
alu_ready  output  1  ALU request accepted this cycle (combinational).
mem_valid  input  1  load writeback request.
mem_addr  input  ADDR_W  load destination register.
mem_data  input  DATA_W  load data.
mem_ready  output  1  load request accepted this cycle (combinational).
rf_write  output  1  register-file write enable (registered).
rf_wrAddr  output  ADDR_W  register-file write address (registered).
rf_wrData  output  DATA_W  register-file write data (registered).
reserve_valid  input  1  decode marks a destination as pending.
reserve_addr  input  ADDR_W  register being reserved.
rd_addr_a  input  ADDR_W  read port A address under check.
rd_addr_b  input  ADDR_W  read port B address under check.
hazard_a  output  1  port A register not yet safely written (combinational).
hazard_b  output  1  port B register not yet safely written (combinational).
pending_cnt  output  ADDR_W+1  number of set scoreboard bits (registered).

Behaviour:
- Reset (synchronous):
  - rf_write=0, rf_wrAddr=0, rf_wrData=0.
  - Scoreboard cleared to all zero; pending_cnt=0.
  - Priority pointer set to INIT_PRI_MEM.
  - alu_ready=0 and mem_ready=0 while reset is high.
- Arbitration: at most one grant per cycle.
  - Only one valid: that requester is granted.
  - Both valid: the requester selected by the pointer is granted. The pointer then flips to the other requester (round-robin).
  - The pointer changes only on a contended grant.
  - ready equals grant. Handshake completes on valid&&ready. A requester that is not granted must hold valid, addr and data stable.
- Write latency: a grant at edge N produces rf_write=1 with the granted addr/data during cycle N+1 (one cycle). With no grant, rf_write=0 next cycle and addr/data hold their last values.
- Address 0:
  - A request to register 0 is accepted (ready=1).
  - It produces rf_write=0 and leaves the scoreboard untouched.
  - It still takes part in arbitration and the pointer rules.
- Scoreboard:
  - reserve_valid sets pending[reserve_addr]; reserve to address 0 is ignored.
  - A granted write clears pending[addr] at the grant edge.
  - Simultaneous reserve and clear of the same address leaves the bit set (the new producer wins).
  - Reserving a bit that is already set leaves it set and the count unchanged.
  - pending_cnt is updated in the same edge as the bits.
- Hazards:
  - hazard_x = pending[rd_addr_x] OR (rf_write && rf_wrAddr==rd_addr_x && rd_addr_x!=0).
  - The second term covers the register file's registered read, which returns old data on the write edge.
  - Address 0 never produces a hazard.
- Reset mid-operation: in-flight writes are dropped (rf_write=0 next cycle) and all pending bits are lost.

Test Plan:
- Reset, then alu_valid with addr 5 and data 32'hDEADBEEF → alu_ready=1 that cycle; next cycle rf_write=1, rf_wrAddr=5, rf_wrData=DEADBEEF; the cycle after, rf_write=0.
- Contention with INIT_PRI_MEM=1: both valid and held for 2 cycles (mem addr 3, alu addr 4) → cycle 1 grants mem and rf_wrAddr=3 follows; cycle 2 grants alu and rf_wrAddr=4 follows; no write is lost.
- Scoreboard:
  - Reserve reg 7 → hazard_a=1 when rd_addr_a=7, pending_cnt=1.
  - Grant mem write to reg 7 → hazard_a stays 1 for the rf_write cycle, then 0; pending_cnt=0.
- Same-cycle clear and reserve of reg 9 → bit stays set, pending_cnt unchanged, hazard_b=1 for rd_addr_b=9.
- Write and reserve to reg 0 → ready=1, rf_write stays 0, pending_cnt=0, hazard_a=0 for rd_addr_a=0.
- Assert reset while a granted write is in flight and 3 registers are reserved → next cycle rf_write=0, pending_cnt=0, both ready=0 during reset.
